// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_loader
// Desc   : Encodes RV32I field bundles into machine words and loads them
//          sequentially into instruction memory through a 2-entry FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W+1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W+1:0] c_base = (ADDR_W+2)'(BASE_ADDR);
    localparam logic [ADDR_W+1:0] c_cap  = (ADDR_W+2)'(2**ADDR_W);
    localparam logic [ADDR_W:0]   c_last = (ADDR_W+1)'(2**ADDR_W - 1);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_fifo [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_occ;
    logic [ADDR_W+1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_accept;
    logic              w_no_room;
    logic              w_push;
    logic              w_pop;
    logic              w_active;

    // Field bundle -> machine word; w_legal flags classes/offsets that must be dropped.
    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (in_class)
            4'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, c_op_r};
            4'd1: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    w_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, c_op_imm};
                else
                    w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_op_imm};
            end
            4'd2: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_op_load};
            4'd3: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], c_op_store};
            4'd4: begin
                w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], c_op_branch};
                w_legal = ~in_imm[0];
            end
            4'd5: begin
                w_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, c_op_jal};
                w_legal = ~in_imm[0];
            end
            4'd6: w_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, c_op_jalr};
            4'd7: w_word = {in_imm[31:12], in_rd, c_op_lui};
            4'd8: w_word = {in_imm[31:12], in_rd, c_op_auipc};
            default: w_legal = 1'b0;
        endcase
    end

    assign w_active  = (r_state == S_LOADING) || (r_state == S_DRAIN);
    assign in_ready  = (r_state == S_LOADING) && (r_occ != 2'd2);
    assign mem_we    = w_active && (r_occ != 2'd0);
    assign mem_wdata = r_fifo[r_rptr];
    assign mem_addr  = r_addr;
    assign busy      = w_active;
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign count     = r_count;

    // Written words plus queued words may never exceed imem capacity.
    assign w_no_room = (({1'b0, r_count} + (ADDR_W+2)'(r_occ)) == c_cap);
    assign w_accept  = in_valid && in_ready && !start;
    assign w_push    = w_accept && w_legal && !w_no_room;
    assign w_pop     = mem_we && mem_ready && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_occ     <= 2'd0;
            r_addr    <= c_base;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else if (start) begin
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_occ     <= 2'd0;
            r_addr    <= c_base;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_word;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr  <= ~r_rptr;
                r_count <= r_count + (ADDR_W+1)'(1);
                // Pointer parks on the last word once imem is full instead of wrapping.
                if (r_count != c_last)
                    r_addr <= r_addr + (ADDR_W+2)'(4);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            if (w_accept && (!w_legal || w_no_room))
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_LOADING;
        end else begin
            case (r_state)
                S_LOADING: if (finish) w_state_nxt = S_DRAIN;
                S_DRAIN:   if (r_occ == 2'd0) w_state_nxt = S_DONE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_encoder_loader
// Desc   : Directed and randomized checks of instr_encoder_loader (ADDR_W=2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_encoder_loader;

    localparam int AW  = 2;
    localparam int CAP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_class = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          mem_we;
    logic [AW+1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   count;

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Reference encoder built from shifts and masks of the field values.
    function automatic logic [31:0] model_enc(input logic [31:0] cls, rd, rs1, rs2, f3, f7, imm,
                                              output bit legal);
        logic [31:0] w;
        legal = 1'b1;
        w = 0;
        case (cls)
            0: w = 'h33 | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
            1: if (f3 == 1 || f3 == 5)
                   w = 'h13 | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 31) << 20 | f7 << 25;
               else
                   w = 'h13 | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 'hFFF) << 20;
            2: w = 'h03 | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 'hFFF) << 20;
            3: w = 'h23 | (imm & 31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((imm >> 5) & 127) << 25;
            4: begin
                w = 'h63 | ((imm >> 11) & 1) << 7 | ((imm >> 1) & 15) << 8 | f3 << 12 | rs1 << 15
                    | rs2 << 20 | ((imm >> 5) & 63) << 25 | ((imm >> 12) & 1) << 31;
                legal = (imm & 1) == 0;
            end
            5: begin
                w = 'h6F | rd << 7 | ((imm >> 12) & 255) << 12 | ((imm >> 11) & 1) << 20
                    | ((imm >> 1) & 1023) << 21 | ((imm >> 20) & 1) << 31;
                legal = (imm & 1) == 0;
            end
            6: w = 'h67 | rd << 7 | rs1 << 15 | (imm & 'hFFF) << 20;
            7: w = 'h37 | rd << 7 | (imm & 'hFFFFF000);
            8: w = 'h17 | rd << 7 | (imm & 'hFFFFF000);
            default: legal = 1'b0;
        endcase
        return w;
    endfunction

    // Model state: phase flags, queued words, words written, sticky error.
    bit          m_load, m_drain, m_done, m_err;
    int          m_count;
    logic [31:0] m_q[$];
    logic [31:0] wlog_d[$];
    logic [31:0] wlog_a[$];

    bit          e_rdy, e_we, m_legal, m_push;
    int          e_addr, n_pre;
    logic [31:0] m_word;

    always @(negedge clk) begin
        if (rst) begin
            m_load = 0; m_drain = 0; m_done = 0; m_err = 0; m_count = 0;
            m_q.delete();
            chk("rst_mem_we", mem_we, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_count", count, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
        end else begin
            e_rdy  = m_load && (m_q.size() < 2);
            e_we   = (m_load || m_drain) && (m_q.size() > 0);
            e_addr = 4 * ((m_count < CAP) ? m_count : CAP - 1);
            chk("in_ready", in_ready, e_rdy);
            chk("mem_we", mem_we, e_we);
            chk("busy", busy, m_load || m_drain);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("count", count, m_count);
            chk("mem_addr", mem_addr, e_addr);
            if (e_we && mem_we) chk("mem_wdata", mem_wdata, m_q[0]);
            if (mem_we && mem_ready && !start) begin
                wlog_d.push_back(mem_wdata);
                wlog_a.push_back(32'(mem_addr));
            end
            if (start) begin
                m_q.delete();
                m_count = 0; m_err = 0;
                m_load = 1; m_drain = 0; m_done = 0;
            end else begin
                n_pre  = m_q.size();
                m_push = 0;
                if (in_valid && e_rdy) begin
                    m_word = model_enc(32'(in_class), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                                       32'(in_funct3), 32'(in_funct7), in_imm, m_legal);
                    if (!m_legal || (m_count + n_pre == CAP)) m_err = 1;
                    else m_push = 1;
                end
                if (e_we && mem_ready) begin
                    void'(m_q.pop_front());
                    m_count++;
                end
                if (m_push) m_q.push_back(m_word);
                if (m_load && finish) begin
                    m_load = 0; m_drain = 1;
                end else if (m_drain && n_pre == 0) begin
                    m_drain = 0; m_done = 1;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        wlog_d.delete();
        wlog_a.delete();
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        sync();
        finish = 1'b0;
    endtask

    task automatic set_b(input logic [3:0] c, input logic [4:0] d, s1, s2,
                         input logic [2:0] f3v, input logic [6:0] f7v, input logic [31:0] iv);
        in_class = c; in_rd = d; in_rs1 = s1; in_rs2 = s2;
        in_funct3 = f3v; in_funct7 = f7v; in_imm = iv;
        in_valid = 1'b1;
    endtask

    task automatic wait_acc();
        bit ok = 0;
        int t  = 0;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = in_ready;
            sync();
            t++;
        end
        in_valid = 1'b0;
        chk("accept_in_time", ok, 1);
    endtask

    task automatic send(input logic [3:0] c, input logic [4:0] d, s1, s2,
                        input logic [2:0] f3v, input logic [6:0] f7v, input logic [31:0] iv);
        set_b(c, d, s1, s2, f3v, f7v, iv);
        wait_acc();
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 50) begin
            sync();
            t++;
        end
        chk("done_in_time", done, 1);
    endtask

    task automatic pin(input string name, input int c, rd, rs1, rs2, f3, f7,
                       input logic [31:0] imm, input logic [31:0] exp, input bit exp_legal);
        bit lg;
        logic [31:0] w;
        w = model_enc(c, rd, rs1, rs2, f3, f7, imm, lg);
        chk(name, lg, exp_legal);
        if (exp_legal) chk(name, w, exp);
    endtask

    initial begin
        pin("pin_opimm", 1, 1, 0, 0, 0, 0, 5, 32'h00500093, 1);
        pin("pin_r0", 0, 3, 1, 2, 0, 0, 0, 32'h002081B3, 1);
        pin("pin_r20", 0, 3, 1, 2, 0, 'h20, 0, 32'h402081B3, 1);
        pin("pin_store", 3, 0, 1, 2, 2, 0, 8, 32'h0020A423, 1);
        pin("pin_branch", 4, 0, 1, 2, 0, 0, 32'hFFFFFFFC, 32'hFE208EE3, 1);
        pin("pin_jal", 5, 1, 0, 0, 0, 0, 8, 32'h008000EF, 1);
        pin("pin_lui", 7, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7, 1);
        pin("pin_jalr", 6, 1, 2, 0, 7, 0, 4, 32'h004100E7, 1);
        pin("pin_br_odd", 4, 0, 1, 2, 0, 0, 3, 0, 0);
        pin("pin_illegal", 12, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_addr", mem_addr, 0);
        sync();

        // Single OP-IMM write, visible the cycle after accept.
        mem_ready = 1'b1;
        do_start();
        send(1, 1, 0, 0, 0, 0, 5);
        @(negedge clk);
        chk("t1_we", mem_we, 1);
        chk("t1_wdata", mem_wdata, 32'h00500093);
        chk("t1_addr", mem_addr, 0);
        sync();
        do_finish();
        wait_done();
        chk("t1_count", count, 1);

        do_start();
        send(0, 3, 1, 2, 0, 0, 0);
        send(0, 3, 1, 2, 0, 7'h20, 0);
        send(3, 0, 1, 2, 2, 0, 8);
        do_finish();
        wait_done();
        chk("t2_n", wlog_d.size(), 3);
        chk("t2_w0", wlog_d[0], 32'h002081B3);
        chk("t2_w1", wlog_d[1], 32'h402081B3);
        chk("t2_w2", wlog_d[2], 32'h0020A423);
        chk("t2_a2", wlog_a[2], 8);

        do_start();
        send(4, 0, 1, 2, 0, 0, 32'hFFFFFFFC);
        send(5, 1, 0, 0, 0, 0, 8);
        send(7, 5, 0, 0, 0, 0, 32'h12345000);
        do_finish();
        wait_done();
        chk("t3_w0", wlog_d[0], 32'hFE208EE3);
        chk("t3_w1", wlog_d[1], 32'h008000EF);
        chk("t3_w2", wlog_d[2], 32'h123452B7);

        // Backpressure: third bundle waits until the FIFO drains.
        mem_ready = 1'b0;
        do_start();
        send(1, 1, 0, 0, 0, 0, 5);
        send(0, 3, 1, 2, 0, 0, 0);
        set_b(3, 0, 1, 2, 2, 0, 8);
        repeat (3) begin
            @(negedge clk);
            chk("t4_not_ready", in_ready, 0);
            chk("t4_we", mem_we, 1);
            chk("t4_hold", mem_wdata, 32'h00500093);
            sync();
        end
        mem_ready = 1'b1;
        wait_acc();
        do_finish();
        wait_done();
        chk("t4_n", wlog_d.size(), 3);
        chk("t4_w0", wlog_d[0], 32'h00500093);
        chk("t4_w1", wlog_d[1], 32'h002081B3);
        chk("t4_w2", wlog_d[2], 32'h0020A423);
        chk("t4_a1", wlog_a[1], 4);
        chk("t4_a2", wlog_a[2], 8);

        // Errors: illegal class, odd branch offset, capacity overflow.
        do_start();
        send(15, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_cls_err", err, 1);
        chk("t5_cls_we", mem_we, 0);
        sync();
        do_start();
        send(4, 0, 1, 2, 0, 0, 3);
        @(negedge clk);
        chk("t5_br_err", err, 1);
        chk("t5_br_we", mem_we, 0);
        chk("t5_br_count", count, 0);
        sync();
        do_start();
        for (int i = 0; i < 5; i++) send(1, 5'(i + 1), 0, 0, 0, 0, 32'(i));
        repeat (4) sync();
        @(negedge clk);
        chk("t5_full_count", count, 4);
        chk("t5_full_err", err, 1);
        chk("t5_full_addr", mem_addr, 12);
        sync();
        do_start();
        @(negedge clk);
        chk("t5_clr_err", err, 0);
        chk("t5_clr_count", count, 0);
        sync();

        // Async reset mid-stall, then start during DRAIN.
        mem_ready = 1'b0;
        send(1, 1, 0, 0, 0, 0, 5);
        @(negedge clk);
        chk("t6_stall_we", mem_we, 1);
        sync();
        rst = 1'b1;
        #1;
        chk("t6_async_we", mem_we, 0);
        chk("t6_async_busy", busy, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_we", mem_we, 0);
        chk("t6_post_ready", in_ready, 0);
        sync();
        do_start();
        send(1, 1, 0, 0, 0, 0, 5);
        send(1, 2, 0, 0, 0, 0, 6);
        do_finish();
        @(negedge clk);
        chk("t6_drain_ready", in_ready, 0);
        chk("t6_drain_busy", busy, 1);
        sync();
        do_start();
        @(negedge clk);
        chk("t6_rs_we", mem_we, 0);
        chk("t6_rs_count", count, 0);
        chk("t6_rs_ready", in_ready, 1);
        chk("t6_rs_addr", mem_addr, 0);
        sync();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom % 400) == 0;
            start     = ($urandom % 40) == 0;
            finish    = ($urandom % 25) == 0;
            in_valid  = $urandom % 2;
            in_class  = (($urandom % 8) == 0) ? 4'(9 + $urandom % 7) : 4'($urandom % 9);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            in_imm    = $urandom;
            if (($urandom % 4) != 0) in_imm[0] = 1'b0;
            mem_ready = ($urandom % 4) != 0;
            sync();
        end
        rst = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        repeat (2) sync();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
